// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: rv32i types shared by the MEM stage, its bus interface and the lane aligner.
package mem_access_stage_pkg;
    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic       load_regfile;
        logic [4:0] rd;
    } rv32i_control_word;

    typedef enum bit {MEM_IDLE, MEM_ACCESS} mem_stage_state_t;

    typedef struct packed {
        logic              valid;
        rv32i_control_word ctrl;
        rv32i_word         alu_out;
        rv32i_word         mdr;
        rv32i_mem_wmask    rmask;
        rv32i_mem_wmask    wmask;
        rv32i_word         mem_addr;
        rv32i_word         mem_wdata;
        logic              trap;
    } mem_wb_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        return is_load ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (f3 <= F3_W);
    endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory request/response bus between the MEM stage and data memory.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;
    rv32i_word      dmem_address;
    logic           dmem_read;
    logic           dmem_write;
    rv32i_mem_wmask dmem_wmask;
    rv32i_word      dmem_wdata;
    rv32i_word      dmem_rdata;
    logic           dmem_resp;
    modport master (output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
                    input  dmem_rdata, dmem_resp);
    modport slave  (input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
                    output dmem_rdata, dmem_resp);
endinterface

// File: rtl/mem_access_stage_load_store_align.sv
// load_store_align: byte-lane masks, store data shift, load data extraction and misalignment detection.
module load_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]     funct3_i,
    input  logic           is_load_i,
    input  logic [1:0]     off_i,
    input  rv32i_word      rs2_i,
    input  rv32i_word      rdata_i,
    output rv32i_mem_wmask mask_o,
    output rv32i_word      wdata_o,
    output rv32i_word      mdr_o,
    output logic           misalign_o
);
    rv32i_mem_wmask base;
    rv32i_word      shifted;

    // Size decode from funct3[1:0]; illegal encodings are folded into misalign so they trap the same way.
    always_comb begin
        misalign_o = !f3_legal(funct3_i, is_load_i) ||
                     (funct3_i[1:0] == 2'b01 ? off_i[0] : funct3_i[1:0] == 2'b10 ? |off_i : 1'b0);
        base       = funct3_i[1:0] == 2'b00 ? 4'b0001 : funct3_i[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        mask_o     = misalign_o ? 4'b0000 : base << off_i;
        wdata_o    = rs2_i << {off_i, 3'b000};
        shifted    = rdata_i >> {off_i, 3'b000};
        mdr_o      = funct3_i == F3_B  ? {{24{shifted[7]}}, shifted[7:0]} :
                     funct3_i == F3_BU ? {24'b0, shifted[7:0]} :
                     funct3_i == F3_H  ? {{16{shifted[15]}}, shifted[15:0]} :
                     funct3_i == F3_HU ? {16'b0, shifted[15:0]} : shifted;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: rv32i MEM stage; issues data-memory accesses, stalls until response, owns MEM/WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  rv32i_control_word  in_ctrl,
    input  rv32i_word          in_alu_out,
    input  rv32i_word          in_rs2,
    output logic               stall_out,
    mem_access_stage_if.master dmem,
    output logic               wb_valid,
    output rv32i_control_word  wb_ctrl,
    output rv32i_word          wb_alu_out,
    output rv32i_word          wb_mdr,
    output rv32i_mem_wmask     wb_rmask,
    output rv32i_mem_wmask     wb_wmask,
    output rv32i_word          wb_mem_addr,
    output rv32i_word          wb_mem_wdata,
    output logic               wb_trap
);
    mem_stage_state_t state_q, state_d;
    mem_wb_t          wb_q, wb_d, pend_q, pend_d;
    rv32i_word        req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    rv32i_mem_wmask   req_wmask_q, req_wmask_d;
    logic             req_read_q, req_read_d, req_write_q, req_write_d;
    logic             busy, mem_ins, memop;
    rv32i_mem_wmask   al_mask;
    rv32i_word        al_wdata, al_mdr;
    logic             al_mis;

    assign busy = state_q == MEM_ACCESS;

    // While waiting on memory the aligner formats the captured instruction, otherwise the incoming one.
    load_store_align u_align (
        .funct3_i   (busy ? pend_q.ctrl.funct3 : in_ctrl.funct3),
        .is_load_i  (busy ? pend_q.ctrl.mem_read : in_ctrl.mem_read),
        .off_i      (busy ? pend_q.mem_addr[1:0] : in_alu_out[1:0]),
        .rs2_i      (in_rs2),
        .rdata_i    (dmem.dmem_rdata),
        .mask_o     (al_mask),
        .wdata_o    (al_wdata),
        .mdr_o      (al_mdr),
        .misalign_o (al_mis)
    );

    assign dmem.dmem_address = req_addr_q;
    assign dmem.dmem_read    = req_read_q;
    assign dmem.dmem_write   = req_write_q;
    assign dmem.dmem_wmask   = req_wmask_q;
    assign dmem.dmem_wdata   = req_wdata_q;
    assign wb_valid          = wb_q.valid;
    assign wb_ctrl           = wb_q.ctrl;
    assign wb_alu_out        = wb_q.alu_out;
    assign wb_mdr            = wb_q.mdr;
    assign wb_rmask          = wb_q.rmask;
    assign wb_wmask          = wb_q.wmask;
    assign wb_mem_addr       = wb_q.mem_addr;
    assign wb_mem_wdata      = wb_q.mem_wdata;
    assign wb_trap           = wb_q.trap;

    // Next state: launch legal accesses from IDLE, retire them into MEM/WB on the response pulse.
    always_comb begin
        state_d     = state_q;
        wb_d        = wb_q;
        wb_d.valid  = 1'b0;
        pend_d      = pend_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        stall_out   = 1'b0;
        mem_ins     = in_valid & (in_ctrl.mem_read | in_ctrl.mem_write);
        memop       = mem_ins & ~al_mis;
        if (!busy) begin
            stall_out = memop;
            if (memop) begin
                state_d     = MEM_ACCESS;
                req_addr_d  = {in_alu_out[31:2], 2'b00};
                req_wdata_d = in_ctrl.mem_write ? al_wdata : '0;
                req_wmask_d = in_ctrl.mem_write ? al_mask : '0;
                req_read_d  = in_ctrl.mem_read;
                req_write_d = in_ctrl.mem_write;
                pend_d      = '{valid: 1'b1, ctrl: in_ctrl, alu_out: in_alu_out, mdr: '0,
                                rmask: in_ctrl.mem_read ? al_mask : '0,
                                wmask: in_ctrl.mem_write ? al_mask : '0,
                                mem_addr: in_alu_out,
                                mem_wdata: in_ctrl.mem_write ? al_wdata : '0, trap: 1'b0};
            end else if (in_valid) begin
                wb_d = '{valid: 1'b1, ctrl: in_ctrl, alu_out: in_alu_out, mdr: '0, rmask: '0, wmask: '0,
                         mem_addr: mem_ins ? in_alu_out : '0, mem_wdata: '0, trap: mem_ins};
            end
        end else begin
            stall_out = ~dmem.dmem_resp;
            if (dmem.dmem_resp) begin
                state_d     = MEM_IDLE;
                wb_d        = pend_q;
                wb_d.mdr    = req_read_q ? al_mdr : '0;
                req_addr_d  = '0;
                req_wdata_d = '0;
                req_wmask_d = '0;
                req_read_d  = 1'b0;
                req_write_d = 1'b0;
            end
        end
    end

    // State, request and MEM/WB registers; reset drops any in-flight request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MEM_IDLE;
            wb_q        <= '0;
            pend_q      <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_q        <= wb_d;
            pend_q      <= pend_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
        end
    end
endmodule
